// File: rtl/write_data_buffer_responder_pkg.sv
// Shared types and helpers for the PSL buffer-read (write-data) responder.
// PSL numbers ha_brad bits MSB-first, so PSL bit 5 is the LSB of our [5:0] vector.
package write_data_buffer_responder_pkg;

  localparam int TAG_WIDTH       = 8;
  localparam int BRAD_WIDTH      = 6;
  localparam int HALF_SELECT_BIT = 5;
  localparam int DWORD_BITS      = 64;
  localparam int ERR_WIDTH       = 3;

  typedef enum logic [1:0] {
    WDE_TAG_PARITY = 2'd0,
    WDE_ADDRESS    = 2'd1,
    WDE_UNFILLED   = 2'd2
  } write_data_error_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic                 half;
    logic [ERR_WIDTH-1:0] errors;
  } buffer_read_line_t;

  function automatic logic odd_parity64(input logic [DWORD_BITS-1:0] dw);
    return ~^dw;
  endfunction

endpackage

// File: rtl/write_data_buffer_responder_tag_ram.sv
// Simple dual-port synchronous RAM holding staged half-cachelines, indexed {tag, half}.
// The read register is only loaded on rd_en so its output holds between reads.
module write_data_tag_ram
  import write_data_buffer_responder_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int WIDTH = 512
) (
  input  logic                     clock,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Same-edge read sees the pre-write contents (read-before-write).
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/write_data_buffer_responder.sv
// AFU-side buffer-read responder: stages per-tag half-lines and returns them to the PSL
// at a fixed latency, tracking fill state and flagging tag-parity/address/unfilled errors.
module write_data_buffer_responder
  import write_data_buffer_responder_pkg::*;
#(
  parameter int TAG_COUNT  = 256,
  parameter int DATA_WIDTH = 512,
  parameter int BR_LATENCY = 1
) (
  input  logic                             clock,
  input  logic                             rstn,
  input  logic                             enabled_in,
  input  logic                             wr_valid_in,
  input  logic [TAG_WIDTH-1:0]             wr_tag_in,
  input  logic                             wr_half_in,
  input  logic [DATA_WIDTH-1:0]            wr_data_in,
  input  logic                             release_valid_in,
  input  logic [TAG_WIDTH-1:0]             release_tag_in,
  input  logic                             ha_brvalid,
  input  logic [TAG_WIDTH-1:0]             ha_brtag,
  input  logic                             ha_brtagpar,
  input  logic [BRAD_WIDTH-1:0]            ha_brad,
  output logic [DATA_WIDTH-1:0]            ah_brdata,
  output logic [DATA_WIDTH/DWORD_BITS-1:0] ah_brpar,
  output logic                             br_data_valid_out,
  output logic [ERR_WIDTH-1:0]             error_out,
  input  logic                             error_clear_in,
  output logic [31:0]                      read_count_out
);

  localparam int DWORDS   = DATA_WIDTH / DWORD_BITS;
  localparam int DEPTH    = 2 * TAG_COUNT;
  localparam int HALF_IDX = BRAD_WIDTH - 1 - HALF_SELECT_BIT;
  localparam logic [BRAD_WIDTH-1:0] BRAD_OFFSET_MASK = ~(BRAD_WIDTH'(1) << HALF_IDX);

  buffer_read_line_t         br_line;
  logic [TAG_COUNT-1:0][1:0] fill_q;
  logic [BR_LATENCY-1:0]     vld_q;
  logic [DATA_WIDTH-1:0]     ram_rd_data;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [DWORDS-1:0]         brpar_calc;
  logic                      data_seen_q;

  always_comb begin
    br_line       = '0;
    br_line.valid = ha_brvalid & enabled_in;
    br_line.tag   = ha_brtag;
    br_line.half  = ha_brad[HALF_IDX];
    if (br_line.valid) begin
      br_line.errors[WDE_TAG_PARITY] = (ha_brtagpar != ~^ha_brtag);
      br_line.errors[WDE_ADDRESS]    = |(ha_brad & BRAD_OFFSET_MASK);
      br_line.errors[WDE_UNFILLED]   = ~fill_q[ha_brtag][br_line.half];
    end
  end

  // Release first, then the write, so a same-cycle write leaves its half filled.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      fill_q <= '0;
    end else begin
      if (release_valid_in) begin
        fill_q[release_tag_in] <= 2'b00;
      end
      if (wr_valid_in) begin
        fill_q[wr_tag_in][wr_half_in] <= 1'b1;
      end
    end
  end

  write_data_tag_ram #(
    .DEPTH(DEPTH),
    .WIDTH(DATA_WIDTH)
  ) u_tag_ram (
    .clock   (clock),
    .rstn    (rstn),
    .wr_en   (wr_valid_in),
    .wr_addr ({wr_tag_in, wr_half_in}),
    .wr_data (wr_data_in),
    .rd_en   (br_line.valid),
    .rd_addr ({br_line.tag, br_line.half}),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= br_line.valid;
      for (int k = 1; k < BR_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  // The RAM read register is the first latency stage; extra stages only load on a valid slot.
  if (BR_LATENCY == 1) begin : g_lat1
    assign out_data = ram_rd_data;
  end else begin : g_latn
    logic [DATA_WIDTH-1:0] dly_q [BR_LATENCY-1];

    always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
        for (int k = 0; k < BR_LATENCY - 1; k++) begin
          dly_q[k] <= '0;
        end
      end else begin
        if (vld_q[0]) begin
          dly_q[0] <= ram_rd_data;
        end
        for (int k = 1; k < BR_LATENCY - 1; k++) begin
          if (vld_q[k]) begin
            dly_q[k] <= dly_q[k-1];
          end
        end
      end
    end

    assign out_data = dly_q[BR_LATENCY-2];
  end

  assign ah_brdata         = out_data;
  assign br_data_valid_out = vld_q[BR_LATENCY-1];

  always_comb begin
    brpar_calc = '0;
    for (int i = 0; i < DWORDS; i++) begin
      brpar_calc[i] = odd_parity64(ah_brdata[i*DWORD_BITS +: DWORD_BITS]);
    end
  end

  // Parity of all-zero data is all ones, so parity stays 0 until data has been returned.
  assign ah_brpar = (data_seen_q | br_data_valid_out) ? brpar_calc : '0;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      data_seen_q    <= 1'b0;
      error_out      <= '0;
      read_count_out <= '0;
    end else begin
      if (br_data_valid_out) begin
        data_seen_q    <= 1'b1;
        read_count_out <= read_count_out + 32'd1;
      end
      error_out <= (error_clear_in ? '0 : error_out) | br_line.errors;
    end
  end

endmodule

// File: tb/tb_write_data_buffer_responder.sv
// Directed bench for write_data_buffer_responder: latency-1 and latency-3 instances share stimulus.
module tb_write_data_buffer_responder;

  logic         clock = 1'b0;
  logic         rstn;
  logic         enabled_in;
  logic         wr_valid_in;
  logic [7:0]   wr_tag_in;
  logic         wr_half_in;
  logic [511:0] wr_data_in;
  logic         release_valid_in;
  logic [7:0]   release_tag_in;
  logic         ha_brvalid;
  logic [7:0]   ha_brtag;
  logic         ha_brtagpar;
  logic [5:0]   ha_brad;
  logic         error_clear_in;

  logic [511:0] ah_brdata,  ah_brdata3;
  logic [7:0]   ah_brpar,   ah_brpar3;
  logic         br_valid,   br_valid3;
  logic [2:0]   error_out,  error_out3;
  logic [31:0]  read_count, read_count3;

  int n_tests = 0;
  int n_fail  = 0;
  int n_reads = 0;

  always #5 clock = ~clock;

  write_data_buffer_responder #(.BR_LATENCY(1)) dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
    .wr_valid_in(wr_valid_in), .wr_tag_in(wr_tag_in), .wr_half_in(wr_half_in), .wr_data_in(wr_data_in),
    .release_valid_in(release_valid_in), .release_tag_in(release_tag_in),
    .ha_brvalid(ha_brvalid), .ha_brtag(ha_brtag), .ha_brtagpar(ha_brtagpar), .ha_brad(ha_brad),
    .ah_brdata(ah_brdata), .ah_brpar(ah_brpar), .br_data_valid_out(br_valid),
    .error_out(error_out), .error_clear_in(error_clear_in), .read_count_out(read_count)
  );

  write_data_buffer_responder #(.BR_LATENCY(3)) dut3 (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
    .wr_valid_in(wr_valid_in), .wr_tag_in(wr_tag_in), .wr_half_in(wr_half_in), .wr_data_in(wr_data_in),
    .release_valid_in(release_valid_in), .release_tag_in(release_tag_in),
    .ha_brvalid(ha_brvalid), .ha_brtag(ha_brtag), .ha_brtagpar(ha_brtagpar), .ha_brad(ha_brad),
    .ah_brdata(ah_brdata3), .ah_brpar(ah_brpar3), .br_data_valid_out(br_valid3),
    .error_out(error_out3), .error_clear_in(error_clear_in), .read_count_out(read_count3)
  );

  typedef struct {
    logic [7:0]   tag;
    logic [5:0]   brad;
    logic         par_ok;
    logic [511:0] data;
    logic [2:0]   err;
  } vec_t;

  vec_t vecs[7];

  // Repeated byte with bit 0 of doubleword i flipped where b[i] is set, so parity varies per doubleword.
  function automatic logic [511:0] dline(input logic [7:0] b);
    logic [511:0] d;
    d = {64{b}};
    for (int i = 0; i < 8; i++) if (b[i]) d[64*i] = ~d[64*i];
    return d;
  endfunction

  function automatic logic [7:0] exp_par(input logic [511:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = (($countones(d[64*i +: 64]) % 2) == 0);
    return p;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    wr_valid_in      = 1'b0;
    wr_tag_in        = 8'h00;
    wr_half_in       = 1'b0;
    wr_data_in       = '0;
    release_valid_in = 1'b0;
    release_tag_in   = 8'h00;
    ha_brvalid       = 1'b0;
    ha_brtag         = 8'h00;
    ha_brtagpar      = 1'b1;
    ha_brad          = 6'h00;
    error_clear_in   = 1'b0;
  endtask

  task automatic set_write(input logic [7:0] tag, input logic half, input logic [511:0] d);
    wr_valid_in = 1'b1;
    wr_tag_in   = tag;
    wr_half_in  = half;
    wr_data_in  = d;
  endtask

  task automatic do_write(input logic [7:0] tag, input logic half, input logic [511:0] d);
    set_idle();
    set_write(tag, half, d);
    step();
    set_idle();
  endtask

  task automatic set_read(input logic [7:0] tag, input logic [5:0] brad, input logic par_ok);
    ha_brvalid  = 1'b1;
    ha_brtag    = tag;
    ha_brad     = brad;
    ha_brtagpar = par_ok ? ~^tag : ^tag;
    if (enabled_in) n_reads++;
  endtask

  task automatic chk_all_zero(input string who, input logic [511:0] d, input logic [7:0] p,
                              input logic v, input logic [2:0] e, input logic [31:0] c);
    chk({who, "_data_zero"},  d, '0);
    chk({who, "_par_zero"},   p, '0);
    chk({who, "_valid_zero"}, v, '0);
    chk({who, "_err_zero"},   e, '0);
    chk({who, "_count_zero"}, c, '0);
  endtask

  localparam logic [511:0] LINE_A5 = {64{8'hA5}};
  localparam logic [511:0] LINE_3C = {64{8'h3C}};

  initial begin
    set_idle();
    enabled_in = 1'b1;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk_all_zero("reset_l1", ah_brdata, ah_brpar, br_valid, error_out, read_count);
    chk_all_zero("reset_l3", ah_brdata3, ah_brpar3, br_valid3, error_out3, read_count3);
    repeat (2) @(posedge clock);
    @(negedge clock) rstn = 1'b1;

    // Back-to-back reads of both halves of tag 0x05.
    do_write(8'h05, 1'b0, LINE_A5);
    do_write(8'h05, 1'b1, LINE_3C);
    set_read(8'h05, 6'h00, 1'b1);
    step();
    chk("b2b_data0", ah_brdata, LINE_A5);
    chk("b2b_valid0", br_valid, 1'b1);
    chk("b2b_par0", ah_brpar, 8'hFF);
    set_idle();
    set_read(8'h05, 6'h01, 1'b1);
    step();
    chk("b2b_data1", ah_brdata, LINE_3C);
    chk("b2b_valid1", br_valid, 1'b1);
    set_idle();
    step();
    chk("hold_valid", br_valid, 1'b0);
    chk("hold_data", ah_brdata, LINE_3C);
    chk("b2b_count", read_count, 32'd2);
    chk("b2b_err", error_out, 3'b000);

    // Table-driven single reads; each read also pulses clear, so error_out shows only its own flags.
    do_write(8'h07, 1'b0, dline(8'h77));
    do_write(8'h07, 1'b1, dline(8'h78));
    do_write(8'h0A, 1'b0, dline(8'h0A));
    set_idle();
    release_valid_in = 1'b1;
    release_tag_in   = 8'h0A;
    step();
    vecs[0] = '{tag: 8'h05, brad: 6'h00, par_ok: 1'b1, data: LINE_A5,      err: 3'b000};
    vecs[1] = '{tag: 8'h05, brad: 6'h01, par_ok: 1'b1, data: LINE_3C,      err: 3'b000};
    vecs[2] = '{tag: 8'h07, brad: 6'h00, par_ok: 1'b0, data: dline(8'h77), err: 3'b001};
    vecs[3] = '{tag: 8'h07, brad: 6'h21, par_ok: 1'b1, data: dline(8'h78), err: 3'b010};
    vecs[4] = '{tag: 8'h0A, brad: 6'h00, par_ok: 1'b1, data: dline(8'h0A), err: 3'b100};
    vecs[5] = '{tag: 8'h05, brad: 6'h20, par_ok: 1'b0, data: LINE_A5,      err: 3'b011};
    vecs[6] = '{tag: 8'h07, brad: 6'h3F, par_ok: 1'b0, data: dline(8'h78), err: 3'b011};
    for (int i = 0; i < 7; i++) begin
      set_idle();
      set_read(vecs[i].tag, vecs[i].brad, vecs[i].par_ok);
      error_clear_in = 1'b1;
      step();
      chk($sformatf("vec%0d_data", i), ah_brdata, vecs[i].data);
      chk($sformatf("vec%0d_par", i), ah_brpar, exp_par(vecs[i].data));
      chk($sformatf("vec%0d_valid", i), br_valid, 1'b1);
      chk($sformatf("vec%0d_err", i), error_out, vecs[i].err);
    end
    set_idle();
    step();
    chk("table_count", read_count, n_reads);

    // Sticky errors and clear.
    set_read(8'h07, 6'h00, 1'b0);
    error_clear_in = 1'b1;
    step();
    chk("sticky_tagpar", error_out, 3'b001);
    set_idle();
    set_read(8'h07, 6'h21, 1'b1);
    step();
    chk("sticky_both", error_out, 3'b011);
    set_idle();
    step();
    step();
    chk("sticky_hold", error_out, 3'b011);
    error_clear_in = 1'b1;
    step();
    set_idle();
    chk("sticky_cleared", error_out, 3'b000);

    // Release leaves the half unfilled, but RAM still holds the old data.
    do_write(8'h09, 1'b0, dline(8'h91));
    release_valid_in = 1'b1;
    release_tag_in   = 8'h09;
    step();
    set_idle();
    set_read(8'h09, 6'h00, 1'b1);
    step();
    chk("released_err", error_out, 3'b100);
    chk("released_data", ah_brdata, dline(8'h91));

    // Same-cycle write and read of one entry returns the old data.
    do_write(8'h09, 1'b0, dline(8'h91));
    set_write(8'h09, 1'b0, dline(8'h92));
    set_read(8'h09, 6'h00, 1'b1);
    error_clear_in = 1'b1;
    step();
    chk("collide_old_data", ah_brdata, dline(8'h91));
    chk("collide_err", error_out, 3'b000);
    set_idle();
    set_read(8'h09, 6'h00, 1'b1);
    step();
    chk("collide_new_data", ah_brdata, dline(8'h92));

    // Same-cycle release and write: only the written half remains filled.
    do_write(8'h0B, 1'b0, dline(8'hB0));
    release_valid_in = 1'b1;
    release_tag_in   = 8'h0B;
    set_write(8'h0B, 1'b1, dline(8'hB1));
    step();
    set_idle();
    set_read(8'h0B, 6'h01, 1'b1);
    error_clear_in = 1'b1;
    step();
    chk("relwr_h1_err", error_out, 3'b000);
    chk("relwr_h1_data", ah_brdata, dline(8'hB1));
    set_idle();
    set_read(8'h0B, 6'h00, 1'b1);
    error_clear_in = 1'b1;
    step();
    chk("relwr_h0_err", error_out, 3'b100);
    chk("relwr_h0_data", ah_brdata, dline(8'hB0));

    // Pipelined reads of tags 0x00..0x0F: latency 1 and latency 3 instances.
    for (int t = 0; t < 16; t++) do_write(8'(t), 1'b0, dline(8'hC0 + 8'(t)));
    error_clear_in = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      set_idle();
      if (k < 16) set_read(8'(k), 6'h00, 1'b1);
      step();
      chk($sformatf("lat1_valid%0d", k), br_valid, k < 16);
      if (k < 16) chk($sformatf("lat1_data%0d", k), ah_brdata, dline(8'hC0 + 8'(k)));
      chk($sformatf("lat3_valid%0d", k), br_valid3, (k >= 2) && (k < 18));
      if ((k >= 2) && (k < 18)) chk($sformatf("lat3_data%0d", k), ah_brdata3, dline(8'hC0 + 8'(k - 2)));
    end
    set_idle();
    step();
    chk("lat_err", error_out, 3'b000);
    chk("lat_count_l1", read_count, n_reads);
    chk("lat_count_l3", read_count3, n_reads);

    // Reads are ignored while disabled.
    enabled_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_idle();
      set_read(8'hEE, 6'h3F, 1'b0);
      step();
      chk($sformatf("dis_valid%0d", k), br_valid, 1'b0);
      chk($sformatf("dis_err%0d", k), error_out, 3'b000);
    end
    set_idle();
    enabled_in = 1'b1;
    repeat (3) step();
    chk("dis_valid3", br_valid3, 1'b0);
    chk("dis_count_l1", read_count, n_reads);
    chk("dis_count_l3", read_count3, n_reads);

    // Reset one cycle after a read drops it and clears fill state.
    set_read(8'h05, 6'h00, 1'b0);
    step();
    set_idle();
    chk("pre_reset_err", error_out, 3'b001);
    #1 rstn = 1'b0;
    #1;
    chk_all_zero("midrst_l1", ah_brdata, ah_brpar, br_valid, error_out, read_count);
    chk_all_zero("midrst_l3", ah_brdata3, ah_brpar3, br_valid3, error_out3, read_count3);
    n_reads = 0;
    repeat (2) @(posedge clock);
    @(negedge clock) rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("postrst_valid_l3_%0d", k), br_valid3, 1'b0);
      chk($sformatf("postrst_valid_l1_%0d", k), br_valid, 1'b0);
    end
    set_read(8'h05, 6'h00, 1'b1);
    step();
    set_idle();
    chk("postrst_unfilled_err", error_out, 3'b100);
    chk("postrst_data", ah_brdata, dline(8'hC5));
    chk("postrst_valid", br_valid, 1'b1);
    step();
    chk("postrst_count", read_count, n_reads);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/write_data_buffer_responder.md
Name: write_data_buffer_responder

Overview:
- AFU-side transmitter for the PSL buffer-read interface. It is the write-direction counterpart of the buffer-write receiver.
- Compute-unit write paths stage 128-byte cachelines per tag as two 64-byte halves.
- When the PSL issues a buffer-read (ha_brvalid/ha_brtag/ha_brad), the block returns the selected half on ah_brdata/ah_brpar at a fixed latency.
- It tracks per-tag fill state, checks tag parity and address, and reports errors to the error-control path.

Parameters:
- TAG_COUNT, 256, number of command tags (tag width 8).
- DATA_WIDTH, 512, bits per half-cacheline (CACHELINE_SIZE_BITS_HF).
- BR_LATENCY, 1, cycles from ha_brvalid to ah_brdata. Legal values are 1..3 and must match the PSL brlat setting.

Ports:
- clock  in  1  single clock
- rstn  in  1  asynchronous active-low reset
- enabled_in  in  1  when low, PSL reads are ignored; AFU writes are still accepted
- wr_valid_in  in  1  AFU stages one half-line this cycle
- wr_tag_in  in  8  tag of staged data
- wr_half_in  in  1  0 = bytes 0-63, 1 = bytes 64-127
- wr_data_in  in  512  half-line data
- release_valid_in  in  1  tag response received; clear that tag's fill state
- release_tag_in  in  8  tag to release
- ha_brvalid  in  1  PSL buffer-read valid
- ha_brtag  in  8  buffer-read tag
- ha_brtagpar  in  1  odd parity of ha_brtag
- ha_brad  in  6  buffer-read address; only bit 5 selects the half
- ah_brdata  out  512  returned data
- ah_brpar  out  8  odd parity, one bit per 64-bit doubleword
- br_data_valid_out  out  1  marks the cycle ah_brdata is meaningful (bench/trace only; not a PSL signal)
- error_out  out  3  sticky flags: [0] tag parity, [1] address, [2] read of unfilled half
- error_clear_in  in  1  clears error_out
- read_count_out  out  32  buffer-reads served

Behaviour:
- Reset (rstn low, asynchronous):
  - All outputs go to 0.
  - Fill bits (2 per tag) clear, pipeline valids clear, read_count_out clears.
  - RAM contents are not cleared.
  - Reset during an outstanding read drops that read; no data cycle follows after reset releases.
- AFU write:
  - On wr_valid_in, the RAM entry {wr_tag_in, wr_half_in} is written at the clock edge and fill[tag][half] is set.
  - Writes are always accepted; no backpressure.
- Release:
  - release_valid_in clears fill[tag][0] and fill[tag][1].
  - If a release and a write hit the same tag in the same cycle, the release applies first; the written half ends up filled.
- PSL read pipeline, on ha_brvalid && enabled_in:
  - Stage 0 registers tag, half = ha_brad[5], and the error checks.
  - The RAM is read synchronously.
  - Delay registers are inserted so ah_brdata, ah_brpar and br_data_valid_out update exactly BR_LATENCY cycles after ha_brvalid.
  - One read per cycle, fully pipelined, back-to-back allowed.
- Read/write collision: a same-cycle read and AFU write to the same {tag, half} return the OLD data (read-before-write).
- Hold between reads: ah_brdata/ah_brpar keep their last value when no read is in flight. br_data_valid_out is high for one cycle per read.
- Parity:
  - ah_brpar[i] = ~^ah_brdata[64i +: 64] (odd parity).
  - Tag check: an error is raised when ha_brtagpar != ~^ha_brtag.
- Errors:
  - [0] tag parity mismatch.
  - [1] ha_brad[0:4] != 0.
  - [2] fill bit for the addressed half is clear.
  - Data is still returned on any error.
  - Flags set at stage 0 and are sticky until error_clear_in. If a clear and a new error coincide, the new error is set.
- read_count_out increments when br_data_valid_out is high and wraps at 2^32.
- enabled_in low: ha_brvalid is ignored; no counter, error or data-valid activity.

Decomposition:
- AFU_PKG additions:
  - BufferReadLine struct (valid, tag, half, errors).
  - write_data_error_t bit positions.
  - Localparam HALF_SELECT_BIT = 5.
  - Odd-parity function over 64 bits, shared with the read-data checker.
- Sub-module write_data_tag_ram: simple dual-port synchronous RAM, depth 2*TAG_COUNT, width DATA_WIDTH, one write port, one read port, read-before-write.

Test Plan:
- Write tag 0x05 halves 0 and 1 (0xA5 pattern, then 0x3C pattern). Brvalid tag 0x05, brad 0x00, then 0x01, back-to-back, BR_LATENCY=1 -> data 0xA5… at cycle+1 and 0x3C… at cycle+2; ah_brpar = 0xFF for 0xA5 (32 ones per doubleword, even, so the odd-parity bit is 1); read_count_out = 2; error_out = 0.
- BR_LATENCY=3, reads of tags 0x00..0x0F on consecutive cycles -> 16 data cycles, each exactly 3 cycles after its request, in order.
- Read tag 0x07 with ha_brtagpar wrong, then brad = 0x21 -> error_out[0] and error_out[1] set and sticky; pulse error_clear_in -> error_out = 0.
- Write tag 0x09 half 0 only, release tag 0x09, read half 0 -> error_out[2] = 1. In a separate sequence, same-cycle write and read of tag 0x09 half 0 -> old data returned.
- Reset asserted one cycle after ha_brvalid -> outputs 0 immediately; no br_data_valid_out after reset release; fill bits cleared (a read raises error[2]).
- enabled_in = 0 with ha_brvalid pulses -> no data-valid, count unchanged, no errors.
